corral_host: RTL and testbench
==============================

CORRAL_HOST -- requirements
Module: corral_host

Interface
REQ-001 The interface SHALL have the following ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  user move request valid.
- cmd_move  in  3  user move code.
- cmd_ready  out  1  host accepts a move this cycle.
- new_game  in  1  one-cycle request to restart the game.
- res_valid  out  1  result available.
- res_ready  in  1  user consumes the result.
- res_cowboy  out  4  captured cowboy position.
- res_horse  out  4  captured horse position.
- res_gameover  out  1  captured game-over flag.
- res_lostwon  out  1  captured lost/won flag.
- move_count  out  8  moves completed since reset or new game.
- g_enter  out  1  drives the game's enter pin; registered.
- g_move  out  3  drives the game's move pins; registered.
- g_reset  out  1  drives the game's reset pin, active-high; registered.
- g_data  in  4  game serial data nibble.
- g_gameover  in  1  game-over pin.
- g_lostwon  in  1  lost/won pin.
- g_ready  in  1  game ready pin; sampled into res_ready_flag only.
- res_ready_flag  out  1  g_ready captured with the result.

Function
REQ-002 FSM states SHALL be IDLE, ISSUE, CAP_COWBOY, CAP_HORSE, RESULT and GRESET.
REQ-003 cmd_ready SHALL be 1 only in IDLE with over_flag=0 and new_game=0.
REQ-004 In IDLE, cmd_valid&&cmd_ready SHALL register g_enter<=1 and g_move<=cmd_move, and the FSM SHALL go to ISSUE.
REQ-005 In ISSUE, the host SHALL hold g_enter=1 for exactly one cycle, then register g_enter<=0, g_move<=0 and go to CAP_COWBOY.
REQ-006 In CAP_COWBOY, the host SHALL capture g_data into res_cowboy at the clock edge and go to CAP_HORSE.
REQ-007 In CAP_HORSE, the host SHALL capture g_data into res_horse, and g_gameover, g_lostwon and g_ready into res_gameover, res_lostwon and res_ready_flag. It SHALL increment move_count, saturating at 255, and go to RESULT.
REQ-008 Latency SHALL be 4 cycles: the edge accepting the command to the first cycle with res_valid=1.
REQ-009 In RESULT, res_valid SHALL be 1 and all res_* outputs SHALL be held stable until res_ready=1; that edge SHALL go to IDLE.
REQ-010 The over_flag register SHALL be set when a captured res_gameover=1, and cleared only by new_game or reset. While it is set, cmd_ready SHALL be 0.
REQ-011 new_game in IDLE or RESULT SHALL go to GRESET: g_reset=1 for exactly 2 cycles, with move_count, over_flag and res_* cleared, then IDLE.
REQ-012 new_game in ISSUE, CAP_COWBOY or CAP_HORSE SHALL be ignored; the capture SHALL complete.
REQ-013 If new_game and res_ready are both asserted in RESULT, new_game SHALL take priority and the result is discarded.
REQ-014 res_valid SHALL never be 1 outside RESULT.
REQ-015 g_enter SHALL never be 1 in two consecutive cycles.

Reset
REQ-016 On reset_n=0, asynchronously:
- state=IDLE.
- g_enter=0, g_move=0, g_reset=1.
- res_*=0, res_valid=0.
- move_count=0, over_flag=0.
REQ-017 g_reset SHALL deassert on the first clock edge after reset_n rises.
REQ-018 Reset mid-capture SHALL abort the transaction with no partial result presented.

Structure
REQ-019 The package corral_pkg SHALL hold:
- the state enum;
- POS_W=4, MOVE_W=3, CNT_W=8;
- GRESET_CYCLES=2.
REQ-020 The block SHALL be a single module with no sub-module.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset: reset_n low -> all outputs 0 except g_reset=1; one edge after release, g_reset=0 and cmd_ready=1.
- Single move: cmd_move=3'b101, game model data 4'h6 then 4'h9 -> g_enter one cycle with g_move=5; res_valid after 4 cycles; res_cowboy=6, res_horse=9, move_count=1.
- Backpressure: res_ready held low 10 cycles -> res_valid and res values stable; cmd_ready=0 throughout.
- Game over: g_gameover=1 during CAP_HORSE, g_lostwon=1 -> res_gameover=1, res_lostwon=1; cmd_ready stays 0 until new_game; then g_reset for 2 cycles and move_count=0.
- Saturation: 260 accepted moves -> move_count=255.
- Mid-op: reset_n pulsed during CAP_COWBOY -> IDLE, res_valid never asserts; new_game during CAP_HORSE ignored and the result is still presented.

Source files
------------

// File: rtl/corral_pkg.sv
// corral_pkg: shared state encoding and sizing for the corral game host.
package corral_pkg;
   localparam int POS_W         = 4;
   localparam int MOVE_W        = 3;
   localparam int CNT_W         = 8;
   localparam int GRESET_CYCLES = 2;
   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      CAP_COWBOY,
      CAP_HORSE,
      RESULT,
      GRESET
   } state_t;
endpackage

// File: rtl/corral_host.sv
// corral_host: sequences one move into the corral game and captures its serial result.
//   clock/reset_n              : system clock, async active-low reset
//   cmd_valid/cmd_move/cmd_ready: move request handshake
//   new_game                   : restart request (honoured in IDLE and RESULT only)
//   res_*/res_valid/res_ready  : captured result, held until consumed
//   move_count                 : saturating count of completed moves
//   g_enter/g_move/g_reset     : registered pins toward the game
//   g_data/g_gameover/g_lostwon/g_ready : pins from the game
module corral_host
   import corral_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              cmd_valid,
   input  logic [MOVE_W-1:0] cmd_move,
   output logic              cmd_ready,
   input  logic              new_game,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [POS_W-1:0]  res_cowboy,
   output logic [POS_W-1:0]  res_horse,
   output logic              res_gameover,
   output logic              res_lostwon,
   output logic [CNT_W-1:0]  move_count,
   output logic              g_enter,
   output logic [MOVE_W-1:0] g_move,
   output logic              g_reset,
   input  logic [POS_W-1:0]  g_data,
   input  logic              g_gameover,
   input  logic              g_lostwon,
   input  logic              g_ready,
   output logic              res_ready_flag
);
   state_t            state, state_nx;
   logic              over_flag, over_nx;
   logic [1:0]        gr_cnt, gr_cnt_nx;
   logic              g_enter_nx, g_reset_nx;
   logic [MOVE_W-1:0] g_move_nx;
   logic [POS_W-1:0]  cowboy_nx, horse_nx;
   logic              gameover_nx, lostwon_nx, ready_flag_nx;
   logic [CNT_W-1:0]  count_nx;
   logic              start_gr;
   assign cmd_ready = state == IDLE && !over_flag && !new_game;
   assign res_valid = state == RESULT;
   // A restart is only honoured between transactions; mid-capture it is dropped.
   assign start_gr  = new_game && (state == IDLE || state == RESULT);
   always_comb begin
      state_nx      = state;
      over_nx       = over_flag;
      gr_cnt_nx     = gr_cnt;
      g_enter_nx    = 1'b0;
      g_reset_nx    = 1'b0;
      g_move_nx     = g_move;
      cowboy_nx     = res_cowboy;
      horse_nx      = res_horse;
      gameover_nx   = res_gameover;
      lostwon_nx    = res_lostwon;
      ready_flag_nx = res_ready_flag;
      count_nx      = move_count;
      case (state)
         IDLE: if (cmd_valid && cmd_ready) begin
            g_enter_nx = 1'b1;
            g_move_nx  = cmd_move;
            state_nx   = ISSUE;
         end
         ISSUE: begin
            g_move_nx = '0;
            state_nx  = CAP_COWBOY;
         end
         CAP_COWBOY: begin
            cowboy_nx = g_data;
            state_nx  = CAP_HORSE;
         end
         CAP_HORSE: begin
            horse_nx      = g_data;
            gameover_nx   = g_gameover;
            lostwon_nx    = g_lostwon;
            ready_flag_nx = g_ready;
            over_nx       = over_flag || g_gameover;
            count_nx      = &move_count ? move_count : move_count + 1'b1;
            state_nx      = RESULT;
         end
         RESULT: state_nx = res_ready ? IDLE : RESULT;
         GRESET: begin
            // gr_cnt counts cycles already spent with g_reset high.
            g_reset_nx = gr_cnt != 2'(GRESET_CYCLES - 1);
            gr_cnt_nx  = gr_cnt + 1'b1;
            state_nx   = g_reset_nx ? GRESET : IDLE;
         end
         default: state_nx = IDLE;
      endcase
      // Restart outranks a simultaneous res_ready; the pending result is dropped.
      if (start_gr) begin
         state_nx      = GRESET;
         g_reset_nx    = 1'b1;
         gr_cnt_nx     = '0;
         over_nx       = 1'b0;
         count_nx      = '0;
         cowboy_nx     = '0;
         horse_nx      = '0;
         gameover_nx   = 1'b0;
         lostwon_nx    = 1'b0;
         ready_flag_nx = 1'b0;
      end
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         over_flag      <= 1'b0;
         gr_cnt         <= '0;
         g_enter        <= 1'b0;
         g_move         <= '0;
         g_reset        <= 1'b1;
         res_cowboy     <= '0;
         res_horse      <= '0;
         res_gameover   <= 1'b0;
         res_lostwon    <= 1'b0;
         res_ready_flag <= 1'b0;
         move_count     <= '0;
      end else begin
         state          <= state_nx;
         over_flag      <= over_nx;
         gr_cnt         <= gr_cnt_nx;
         g_enter        <= g_enter_nx;
         g_move         <= g_move_nx;
         g_reset        <= g_reset_nx;
         res_cowboy     <= cowboy_nx;
         res_horse      <= horse_nx;
         res_gameover   <= gameover_nx;
         res_lostwon    <= lostwon_nx;
         res_ready_flag <= ready_flag_nx;
         move_count     <= count_nx;
      end
   end
endmodule

// File: tb/tb_corral_host.sv
// tb_corral_host: directed scenarios against corral_host with a result scoreboard.
module tb_corral_host;
   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [2:0] cmd_move = '0;
   logic       cmd_ready;
   logic       new_game = 1'b0;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [3:0] res_cowboy, res_horse;
   logic       res_gameover, res_lostwon;
   logic [7:0] move_count;
   logic       g_enter;
   logic [2:0] g_move;
   logic       g_reset;
   logic [3:0] g_data = '0;
   logic       g_gameover = 1'b0;
   logic       g_lostwon = 1'b0;
   logic       g_ready = 1'b0;
   logic       res_ready_flag;
   typedef struct {
      logic [3:0] cowboy;
      logic [3:0] horse;
      logic       gameover;
      logic       lostwon;
      logic       rdy;
      logic [7:0] count;
   } exp_t;
   exp_t sb[$];
   int   compared = 0;
   int   failed = 0;
   int   model_count = 0;
   logic prev_enter = 1'b0;
   corral_host dut (
      .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_move(cmd_move),
      .cmd_ready(cmd_ready), .new_game(new_game), .res_valid(res_valid), .res_ready(res_ready),
      .res_cowboy(res_cowboy), .res_horse(res_horse), .res_gameover(res_gameover),
      .res_lostwon(res_lostwon), .move_count(move_count), .g_enter(g_enter), .g_move(g_move),
      .g_reset(g_reset), .g_data(g_data), .g_gameover(g_gameover), .g_lostwon(g_lostwon),
      .g_ready(g_ready), .res_ready_flag(res_ready_flag)
   );
   always #5 clock = ~clock;
   always @(negedge clock) begin
      if (g_enter) begin
         compared++;
         if (prev_enter) begin
            failed++;
            $display("FAIL enter_twice: g_enter high on consecutive cycles, required single pulse");
         end
      end
      prev_enter = g_enter;
   end
   // Drives one move with a game model that presents cowboy then horse data,
   // and checks the captured result against the scoreboard on res_valid.
   task automatic issue_move(input logic [2:0] m, input logic [3:0] cow, input logic [3:0] hor,
                             input logic go, input logic lw, input logic rdy, input bit ng_mid);
      exp_t e;
      exp_t got;
      int   n = 0;
      @(negedge clock);
      cmd_valid = 1'b1;
      cmd_move  = m;
      compared++;
      if (cmd_ready !== 1'b1) begin
         failed++;
         $display("FAIL accept_ready: cmd_ready=%b required 1", cmd_ready);
      end
      @(posedge clock);
      model_count = model_count == 255 ? 255 : model_count + 1;
      e = '{cowboy: cow, horse: hor, gameover: go, lostwon: lw, rdy: rdy, count: 8'(model_count)};
      sb.push_back(e);
      do begin
         @(negedge clock);
         n++;
         cmd_valid = 1'b0;
         new_game  = 1'b0;
         if (n == 1) begin
            compared++;
            if (g_enter !== 1'b1 || g_move !== m) begin
               failed++;
               $display("FAIL issue_pins: g_enter=%b g_move=%0d required 1/%0d", g_enter, g_move, m);
            end
            g_data = cow;
         end
         if (n == 2) begin
            compared++;
            if (g_enter !== 1'b0 || g_move !== 3'd0) begin
               failed++;
               $display("FAIL release_pins: g_enter=%b g_move=%0d required 0/0", g_enter, g_move);
            end
         end
         if (n == 3) begin
            g_data     = hor;
            g_gameover = go;
            g_lostwon  = lw;
            g_ready    = rdy;
            new_game   = ng_mid;
         end
      end while (!res_valid && n < 10);
      compared++;
      if (n != 4) begin
         failed++;
         $display("FAIL latency: res_valid after %0d cycles required 4", n);
      end
      if (res_valid && sb.size() > 0) begin
         got = sb.pop_front();
         compared++;
         if (res_cowboy !== got.cowboy || res_horse !== got.horse) begin
            failed++;
            $display("FAIL positions: cowboy=%h horse=%h required %h %h", res_cowboy, res_horse, got.cowboy, got.horse);
         end
         compared++;
         if ({res_gameover, res_lostwon, res_ready_flag} !== {got.gameover, got.lostwon, got.rdy}) begin
            failed++;
            $display("FAIL flags: go/lw/rdy=%b%b%b required %b%b%b", res_gameover, res_lostwon, res_ready_flag, got.gameover, got.lostwon, got.rdy);
         end
         compared++;
         if (move_count !== got.count) begin
            failed++;
            $display("FAIL move_count: got %0d required %0d", move_count, got.count);
         end
      end
      g_data     = '0;
      g_gameover = 1'b0;
      g_lostwon  = 1'b0;
      g_ready    = 1'b0;
   endtask
   task automatic consume();
      res_ready = 1'b1;
      @(negedge clock);
      res_ready = 1'b0;
      compared++;
      if (res_valid !== 1'b0) begin
         failed++;
         $display("FAIL consume: res_valid=%b required 0", res_valid);
      end
   endtask
   task automatic test_reset();
      reset_n = 1'b0;
      #23;
      compared++;
      if ({res_valid, res_cowboy, res_horse, res_gameover, res_lostwon, res_ready_flag, move_count, g_enter, g_move, g_reset} !== 29'd1) begin
         failed++;
         $display("FAIL reset_values: g_reset=%b move_count=%0d res_valid=%b required only g_reset set", g_reset, move_count, res_valid);
      end
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      compared++;
      if (g_reset !== 1'b0 || cmd_ready !== 1'b1) begin
         failed++;
         $display("FAIL reset_release: g_reset=%b cmd_ready=%b required 0/1", g_reset, cmd_ready);
      end
      model_count = 0;
   endtask
   task automatic test_single_move();
      issue_move(3'b101, 4'h6, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0);
      compared++;
      if (res_cowboy !== 4'h6 || res_horse !== 4'h9 || move_count !== 8'd1) begin
         failed++;
         $display("FAIL single_move: cowboy=%h horse=%h count=%0d required 6 9 1", res_cowboy, res_horse, move_count);
      end
      consume();
   endtask
   task automatic test_backpressure();
      bit bad = 0;
      issue_move(3'd3, 4'ha, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0);
      cmd_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (res_valid !== 1'b1 || res_cowboy !== 4'ha || res_horse !== 4'h3 || res_lostwon !== 1'b1 || cmd_ready !== 1'b0 || g_enter !== 1'b0)
            bad = 1;
      end
      cmd_valid = 1'b0;
      compared++;
      if (bad) begin
         failed++;
         $display("FAIL backpressure: result not held (valid=%b cowboy=%h horse=%h cmd_ready=%b)", res_valid, res_cowboy, res_horse, cmd_ready);
      end
      consume();
   endtask
   task automatic test_game_over();
      bit bad = 0;
      issue_move(3'd2, 4'h1, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0);
      compared++;
      if (res_gameover !== 1'b1 || res_lostwon !== 1'b1) begin
         failed++;
         $display("FAIL gameover_capture: go=%b lw=%b required 1 1", res_gameover, res_lostwon);
      end
      consume();
      cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         if (cmd_ready !== 1'b0 || g_enter !== 1'b0) bad = 1;
      end
      cmd_valid = 1'b0;
      compared++;
      if (bad) begin
         failed++;
         $display("FAIL over_blocks: cmd_ready=%b g_enter=%b required 0", cmd_ready, g_enter);
      end
      new_game = 1'b1;
      @(negedge clock);
      new_game = 1'b0;
      model_count = 0;
      compared++;
      if (g_reset !== 1'b1 || move_count !== 8'd0 || res_gameover !== 1'b0 || res_cowboy !== 4'h0) begin
         failed++;
         $display("FAIL greset_entry: g_reset=%b count=%0d go=%b required 1 0 0", g_reset, move_count, res_gameover);
      end
      @(negedge clock);
      compared++;
      if (g_reset !== 1'b1) begin
         failed++;
         $display("FAIL greset_second: g_reset=%b required 1", g_reset);
      end
      @(negedge clock);
      compared++;
      if (g_reset !== 1'b0 || cmd_ready !== 1'b1) begin
         failed++;
         $display("FAIL greset_done: g_reset=%b cmd_ready=%b required 0 1", g_reset, cmd_ready);
      end
   endtask
   task automatic test_saturation();
      for (int i = 0; i < 260; i++) begin
         logic [7:0] v = 8'(i);
         issue_move(v[2:0], v[3:0], ~v[3:0], 1'b0, v[0], v[1], 1'b0);
         consume();
      end
      compared++;
      if (move_count !== 8'd255) begin
         failed++;
         $display("FAIL saturation: move_count=%0d required 255", move_count);
      end
      issue_move(3'd1, 4'h7, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0);
      new_game  = 1'b1;
      res_ready = 1'b1;
      @(negedge clock);
      new_game  = 1'b0;
      res_ready = 1'b0;
      model_count = 0;
      compared++;
      if (res_valid !== 1'b0 || g_reset !== 1'b1 || move_count !== 8'd0 || res_cowboy !== 4'h0) begin
         failed++;
         $display("FAIL newgame_priority: valid=%b g_reset=%b count=%0d required 0 1 0", res_valid, g_reset, move_count);
      end
      repeat (2) @(negedge clock);
   endtask
   task automatic test_mid_op();
      bit bad = 0;
      @(negedge clock);
      cmd_valid = 1'b1;
      cmd_move  = 3'd4;
      @(negedge clock);
      cmd_valid = 1'b0;
      g_data    = 4'hc;
      @(negedge clock);
      reset_n = 1'b0;
      #2;
      compared++;
      if (res_valid !== 1'b0 || g_reset !== 1'b1 || g_enter !== 1'b0 || move_count !== 8'd0) begin
         failed++;
         $display("FAIL midop_reset: valid=%b g_reset=%b g_enter=%b count=%0d", res_valid, g_reset, g_enter, move_count);
      end
      @(negedge clock);
      reset_n = 1'b1;
      model_count = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         if (res_valid !== 1'b0 || res_cowboy !== 4'h0) bad = 1;
      end
      g_data = '0;
      compared++;
      if (bad || cmd_ready !== 1'b1) begin
         failed++;
         $display("FAIL midop_abort: res_valid=%b cowboy=%h cmd_ready=%b required 0 0 1", res_valid, res_cowboy, cmd_ready);
      end
      issue_move(3'd6, 4'h5, 4'hb, 1'b0, 1'b0, 1'b1, 1'b1);
      compared++;
      if (g_reset !== 1'b0 || res_valid !== 1'b1 || move_count !== 8'd1) begin
         failed++;
         $display("FAIL midop_newgame: g_reset=%b valid=%b count=%0d required 0 1 1", g_reset, res_valid, move_count);
      end
      consume();
   endtask
   initial begin
      test_reset();
      test_single_move();
      test_backpressure();
      test_game_over();
      test_saturation();
      test_mid_op();
      compared++;
      if (sb.size() != 0) begin
         failed++;
         $display("FAIL scoreboard_drain: %0d results outstanding required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end
endmodule
